// File: rtl/imem_fetch.sv
// imem_fetch: word-addressed instruction memory with a one-cycle registered
// read, valid/ready handshake towards decode, flush and a run-time load port.
// Optional build macro IMEM_PARITY_EN adds a stored even-parity bit per word
// and a parity_err output flag.
//
// Storage holds each word XOR NOP_WORD (and its parity likewise). A RAM that
// powers up as all zeros therefore reads back NOP_WORD in every location
// without any initialisation logic.
module imem_fetch #(
   parameter int                AWIDTH   = 8,
   parameter int                DWIDTH   = 32,
   parameter int                DEPTH    = 32,
   parameter logic [DWIDTH-1:0] NOP_WORD = 32'h00000013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AWIDTH-1:0] cnt_out,
   input  logic              req_valid,
   output logic              req_ready,
   output logic [DWIDTH-1:0] instruction,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              flush,
   output logic              addr_err,
`ifdef IMEM_PARITY_EN
   output logic              parity_err,
`endif
   input  logic              ld_en,
   input  logic [AWIDTH-1:0] ld_addr,
   input  logic [DWIDTH-1:0] ld_data
);

   localparam int                IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AWIDTH:0]   DEPTH_L = (AWIDTH + 1)'(DEPTH);

   // Memory array (not reset) and the synchronous read register
   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic [DWIDTH-1:0] rd_q;

   // Handshake / output status flops
   logic valid_q, valid_d;
   logic addr_err_q, addr_err_d;
   logic nop_sel_q, nop_sel_d;

   logic accept;
   logic rd_in_range;
   logic ld_in_range;

`ifdef IMEM_PARITY_EN
   logic par_mem_q [DEPTH];
   logic rd_par_q;
   logic par_flag_q, par_flag_d;
`endif

   // Request acceptance and address range decoding
   always_comb begin
      req_ready   = !ld_en && (!valid_q || instr_ready);
      accept      = req_valid && req_ready;
      rd_in_range = {1'b0, cnt_out} < DEPTH_L;
      ld_in_range = {1'b0, ld_addr} < DEPTH_L;
   end

   // Next-state for the output status: flush and consume drop valid, an
   // accept (which wins over flush) loads a fresh word or the NOP marker
   always_comb begin
      valid_d    = valid_q;
      addr_err_d = addr_err_q;
      nop_sel_d  = nop_sel_q;
`ifdef IMEM_PARITY_EN
      par_flag_d = par_flag_q;
`endif
      if (flush) begin
         valid_d    = 1'b0;
         addr_err_d = 1'b0;
`ifdef IMEM_PARITY_EN
         par_flag_d = 1'b0;
`endif
      end else if (valid_q && instr_ready) begin
         valid_d = 1'b0;
      end
      if (accept) begin
         valid_d    = 1'b1;
         addr_err_d = !rd_in_range;
         nop_sel_d  = !rd_in_range;
`ifdef IMEM_PARITY_EN
         par_flag_d = rd_in_range;
`endif
      end
   end

   // Status register with synchronous reset; reset shows NOP_WORD, not valid
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         addr_err_q <= 1'b0;
         nop_sel_q  <= 1'b1;
      end else begin
         valid_q    <= valid_d;
         addr_err_q <= addr_err_d;
         nop_sel_q  <= nop_sel_d;
      end
   end

   // RAM write port and synchronous read port; out-of-range accesses skip it
   always_ff @(posedge clk) begin
      if (!rst && ld_en && ld_in_range) begin
         mem_q[ld_addr[IW-1:0]] <= ld_data ^ NOP_WORD;
      end
      if (!rst && accept && rd_in_range) begin
         rd_q <= mem_q[cnt_out[IW-1:0]];
      end
   end

`ifdef IMEM_PARITY_EN
   // Parity side-array, written and read in lockstep with the data RAM
   always_ff @(posedge clk) begin
      if (!rst && ld_en && ld_in_range) begin
         par_mem_q[ld_addr[IW-1:0]] <= ^(ld_data ^ NOP_WORD);
      end
      if (!rst && accept && rd_in_range) begin
         rd_par_q <= par_mem_q[cnt_out[IW-1:0]];
      end
   end

   // Parity check flag register, armed only by an in-range accept
   always_ff @(posedge clk) begin
      if (rst) begin
         par_flag_q <= 1'b0;
      end else begin
         par_flag_q <= par_flag_d;
      end
   end

   // Compare the stored parity bit against the word that was read
   always_comb begin
      parity_err = par_flag_q && ((^rd_q) != rd_par_q);
   end
`endif

   // Output drive: the read register is only trusted after an in-range accept
   always_comb begin
      instruction = nop_sel_q ? NOP_WORD : (rd_q ^ NOP_WORD);
      instr_valid = valid_q;
      addr_err    = addr_err_q;
   end

endmodule

// File: tb/tb_imem_fetch.sv
// tb_imem_fetch: directed bench for imem_fetch with the default parameters
// (AWIDTH=8, DWIDTH=32, DEPTH=32). Inputs change 1ns after a rising edge and
// outputs are checked there, well away from the next edge.
module tb_imem_fetch;

   localparam logic [31:0] NOP = 32'h00000013;
   localparam logic [31:0] W0  = 32'h00007033;
   localparam logic [31:0] W1  = 32'h00208433;
   localparam logic [31:0] W2  = 32'h404404b3;
   localparam logic [31:0] W3  = 32'h00317533;

   logic        clk;
   logic        rst;
   logic [7:0]  cnt_out;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] instruction;
   logic        instr_valid;
   logic        instr_ready;
   logic        flush;
   logic        addr_err;
   logic        ld_en;
   logic [7:0]  ld_addr;
   logic [31:0] ld_data;
`ifdef IMEM_PARITY_EN
   logic        parity_err;
`endif

   int total;
   int bad;

   imem_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .cnt_out     (cnt_out),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .flush       (flush),
      .addr_err    (addr_err),
`ifdef IMEM_PARITY_EN
      .parity_err  (parity_err),
`endif
      .ld_en       (ld_en),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data)
   );

   // Free-running 10ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle 1ns past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive the request/handshake inputs, then let combinational paths settle
   task automatic applyStimulus(input logic rv, input logic [7:0] addr,
                                input logic ir, input logic fl);
      req_valid   = rv;
      cnt_out     = addr;
      instr_ready = ir;
      flush       = fl;
      #1;
   endtask

   // One comparison: counted, and reported on mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      logic [31:0] words [4];
      total     = 0;
      bad       = 0;
      words[0]  = W0;
      words[1]  = W1;
      words[2]  = W2;
      words[3]  = W3;
      rst       = 1'b1;
      ld_en     = 1'b0;
      ld_addr   = '0;
      ld_data   = '0;
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      #1;

      // Reset state
      checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);
      checkOutput("rst_instr", instruction, NOP);
      checkOutput("rst_addr_err", {31'b0, addr_err}, 32'd0);
      checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);

      // Load words 0..3, plus one out-of-range write that must be dropped
      for (int i = 0; i < 4; i++) begin
         ld_en   = 1'b1;
         ld_addr = 8'(i);
         ld_data = words[i];
         #1;
         checkOutput("ld_blocks_ready", {31'b0, req_ready}, 32'd0);
         tick();
      end
      ld_addr = 8'd40;
      ld_data = 32'hdeadbeef;
      tick();
      ld_en = 1'b0;
      #1;

      // Back-to-back fetch of 0..3, one word per cycle
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
         tick();
         checkOutput($sformatf("b2b_word%0d", i), instruction, words[i]);
         checkOutput($sformatf("b2b_valid%0d", i), {31'b0, instr_valid}, 32'd1);
      end
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
      tick();
      checkOutput("consume_valid", {31'b0, instr_valid}, 32'd0);
      checkOutput("consume_keeps", instruction, W3);

      // Stall: accept 1, hold instr_ready low for three cycles
      applyStimulus(1'b1, 8'd1, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b1, 8'd2, 1'b0, 1'b0);
      checkOutput("stall_req_ready", {31'b0, req_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("stall_hold_instr", instruction, W1);
         checkOutput("stall_hold_valid", {31'b0, instr_valid}, 32'd1);
      end
      applyStimulus(1'b1, 8'd2, 1'b1, 1'b0);
      checkOutput("unstall_req_ready", {31'b0, req_ready}, 32'd1);
      tick();
      checkOutput("unstall_word", instruction, W2);

      // Out-of-range and boundary addresses
      applyStimulus(1'b1, 8'd40, 1'b1, 1'b0);
      tick();
      checkOutput("oor40_instr", instruction, NOP);
      checkOutput("oor40_err", {31'b0, addr_err}, 32'd1);
      checkOutput("oor40_valid", {31'b0, instr_valid}, 32'd1);
      applyStimulus(1'b1, 8'd0, 1'b1, 1'b0);
      tick();
      checkOutput("inrange_clears_err", {31'b0, addr_err}, 32'd0);
      checkOutput("inrange_word", instruction, W0);
      applyStimulus(1'b1, 8'd8, 1'b1, 1'b0);
      tick();
      checkOutput("dropped_write_addr8", instruction, NOP);
      applyStimulus(1'b1, 8'd31, 1'b1, 1'b0);
      tick();
      checkOutput("edge31_instr", instruction, NOP);
      checkOutput("edge31_err", {31'b0, addr_err}, 32'd0);
      applyStimulus(1'b1, 8'd32, 1'b1, 1'b0);
      tick();
      checkOutput("edge32_err", {31'b0, addr_err}, 32'd1);

      // Flush while stalled with an address error held
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
      tick();
      checkOutput("stall_err_hold", {31'b0, addr_err}, 32'd1);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
      tick();
      checkOutput("flush_valid", {31'b0, instr_valid}, 32'd0);
      checkOutput("flush_err", {31'b0, addr_err}, 32'd0);

      // Flush together with an accept of address 3: the new word wins
      applyStimulus(1'b1, 8'd1, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b1, 8'd3, 1'b1, 1'b1);
      tick();
      checkOutput("flush_accept_valid", {31'b0, instr_valid}, 32'd1);
      checkOutput("flush_accept_word", instruction, W3);

      // Write to the held address does not disturb the held output
      applyStimulus(1'b1, 8'd0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
      ld_en   = 1'b1;
      ld_addr = 8'd0;
      ld_data = 32'h11111111;
      tick();
      ld_en = 1'b0;
      checkOutput("write_keeps_held", instruction, W0);
      applyStimulus(1'b1, 8'd0, 1'b1, 1'b0);
      tick();
      checkOutput("read_after_write", instruction, 32'h11111111);

      // Reset beats load and accept
      rst     = 1'b1;
      ld_en   = 1'b1;
      ld_addr = 8'd1;
      ld_data = 32'hcafef00d;
      applyStimulus(1'b1, 8'd2, 1'b1, 1'b0);
      tick();
      rst   = 1'b0;
      ld_en = 1'b0;
      checkOutput("rst_prio_valid", {31'b0, instr_valid}, 32'd0);
      checkOutput("rst_prio_instr", instruction, NOP);
      applyStimulus(1'b1, 8'd1, 1'b1, 1'b0);
      tick();
      checkOutput("rst_blocks_load", instruction, W1);

`ifdef IMEM_PARITY_EN
      // Flip one stored bit of word 2 behind the parity bit's back
      dut.mem_q[2] = dut.mem_q[2] ^ 32'h00000001;
      applyStimulus(1'b1, 8'd2, 1'b1, 1'b0);
      tick();
      checkOutput("parity_err_set", {31'b0, parity_err}, 32'd1);
      checkOutput("parity_word_passthru", instruction, W2 ^ 32'h00000001);
      applyStimulus(1'b1, 8'd3, 1'b1, 1'b0);
      tick();
      checkOutput("parity_err_clear", {31'b0, parity_err}, 32'd0);
`endif

      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
